// File: rtl/vram_scanout.sv
// vram_scanout: 640x480@60 VGA timing, 4x4 pixel-replicated scanout of a 160x120 RGB444 framebuffer via ping-pong line buffers.
// Latency: pins are registered one clock after the (h,v) raster state; VRAM words land READ_LATENCY clocks after their address.
// Backpressure: none; VRAM port is read at one word per clock and assumed always available. Macro SCANOUT_TEST_PATTERN_EN swaps scanout for colour bars.
module vram_scanout #(
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        clear,
    output logic [15:0] vram_addr,
    input  logic [15:0] vram_q,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        frame_start,
    output logic        underrun
);

    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] HS_BEG   = 10'd656;
    localparam logic [9:0] HS_END   = 10'd751;
    localparam logic [9:0] V_LAST   = 10'd524;
    localparam logic [9:0] V_VIS    = 10'd480;
    localparam logic [9:0] VS_BEG   = 10'd490;
    localparam logic [9:0] VS_END   = 10'd491;
    localparam logic [9:0] V_TRIG_LIM = 10'd476;

    // raster position
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;

    // display-valid flag: black screen until the first group-0 prefetch has landed
    logic vid_ok_q, vid_ok_d;

    // registered pin state
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        fs_q, fs_d;

    logic        line_start;
    logic        visible;
    logic        swap_line;
    logic [11:0] pix;

    assign line_start = (h_q == 10'd0);
    assign visible    = (h_q < H_VIS) && (v_q < V_VIS);
    // buffer swap point: start of every fourth visible line
    assign swap_line  = line_start && (v_q < V_VIS) && (v_q[1:0] == 2'b00);

    // Advance the raster counters, h wrapping into v
    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = 10'd0;
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end
    end

    // Raster counter registers
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            h_q <= 10'd0;
            v_q <= 10'd0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

`ifdef SCANOUT_TEST_PATTERN_EN

    logic [2:0] bar;
    logic       unused_vram;

    assign bar         = h_q[9:7];
    assign vram_addr   = BASE_ADDR;
    assign underrun    = 1'b0;
    assign unused_vram = ^vram_q;

    // Colour-bar pixel generator
    always_comb begin
        pix = {{4{bar[0]}}, {4{bar[1]}}, {4{bar[2]}}};
    end

    // Display becomes valid at the same raster point the prefetch would have completed
    always_comb begin
        vid_ok_d = vid_ok_q | (line_start && (v_q == V_LAST));
    end

`else

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] DRAIN_LAST = 2'(READ_LATENCY - 1);
    localparam logic [7:0] IDX_LAST   = 8'd159;

    logic [1:0]  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [6:0]  grp_q, grp_d;
    logic [1:0]  drain_q, drain_d;
    logic [15:0] addr_q, addr_d;
    logic        und_q, und_d;

    // in-flight read tracking: valid bit plus line index per outstanding word
    logic [READ_LATENCY-1:0] pvld_q, pvld_d;
    logic [7:0]              pidx_q [READ_LATENCY];
    logic [7:0]              pidx_d [READ_LATENCY];

    logic [11:0] lb0 [160];
    logic [11:0] lb1 [160];

    logic        trig_first;
    logic        trig_next;
    logic [6:0]  trig_grp;
    logic        wr_en;
    logic [7:0]  wr_idx;
    logic [7:0]  rd_idx;
    logic        unused_vram;

    assign unused_vram = ^vram_q[15:12];

    // line 524 primes group 0; every fourth early line prefetches the next group
    assign trig_first = line_start && (v_q == V_LAST);
    assign trig_next  = line_start && (v_q < V_TRIG_LIM) && (v_q[1:0] == 2'b00);
    assign trig_grp   = trig_first ? 7'd0 : (v_q[8:2] + 7'd1);

    assign wr_en  = pvld_q[READ_LATENCY-1];
    assign wr_idx = pidx_q[READ_LATENCY-1];

    assign vram_addr = addr_q;
    assign underrun  = und_q;

    // Fetch FSM: issue 160 consecutive reads, then wait out the read latency
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        grp_d   = grp_q;
        drain_d = drain_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (trig_first || trig_next) begin
                    state_d = ST_ISSUE;
                    grp_d   = trig_grp;
                    idx_d   = 8'd0;
                    addr_d  = BASE_ADDR + ({9'd0, trig_grp} * 16'd160);
                end
            end
            ST_ISSUE: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = 2'd0;
                end else begin
                    idx_d  = idx_q + 8'd1;
                    addr_d = addr_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift the outstanding-read tags along with the RAM pipeline
    always_comb begin
        pvld_d    = pvld_q;
        pvld_d[0] = (state_q == ST_ISSUE);
        pidx_d[0] = idx_q;
        for (int k = 1; k < READ_LATENCY; k++) begin
            pvld_d[k] = pvld_q[k-1];
            pidx_d[k] = pidx_q[k-1];
        end
    end

    // Sticky underrun and display-valid flag
    always_comb begin
        und_d    = und_q | (swap_line && (state_q != ST_IDLE));
        vid_ok_d = vid_ok_q | ((state_q == ST_DRAIN) && (drain_q == DRAIN_LAST) && (grp_q == 7'd0));
    end

    // Fetch-side state registers
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            idx_q   <= 8'd0;
            grp_q   <= 7'd0;
            drain_q <= 2'd0;
            addr_q  <= BASE_ADDR;
            und_q   <= 1'b0;
            pvld_q  <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pidx_q[k] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            grp_q   <= grp_d;
            drain_q <= drain_d;
            addr_q  <= addr_d;
            und_q   <= und_d;
            pvld_q  <= pvld_d;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pidx_q[k] <= pidx_d[k];
            end
        end
    end

    // Capture returning VRAM words into the buffer of the group being fetched
    always_ff @(posedge clock) begin
        if (wr_en) begin
            if (grp_q[0]) begin
                lb1[wr_idx] <= vram_q[11:0];
            end else begin
                lb0[wr_idx] <= vram_q[11:0];
            end
        end
    end

    // Display read: each buffer word covers four columns and four lines
    always_comb begin
        rd_idx = visible ? h_q[9:2] : 8'd0;
        pix    = v_q[2] ? lb1[rd_idx] : lb0[rd_idx];
    end

`endif

    // Next pin values from the current raster state
    always_comb begin
        rgb_d = (visible && vid_ok_q) ? pix : 12'h000;
        hs_d  = !((h_q >= HS_BEG) && (h_q <= HS_END));
        vs_d  = !((v_q >= VS_BEG) && (v_q <= VS_END));
        fs_d  = line_start && (v_q == 10'd0) && vid_ok_q;
    end

    // Output pin registers and display-valid flag
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            rgb_q    <= 12'h000;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            fs_q     <= 1'b0;
            vid_ok_q <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            fs_q     <= fs_d;
            vid_ok_q <= vid_ok_d;
        end
    end

    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Scoreboard bench for vram_scanout: expectations are queued against a cycle stamp
// (clocks since clear release) and a monitor compares them at the falling edge.
module tb_vram_scanout;

    localparam logic [15:0] BASE = 16'h1000;
    localparam int          LAT  = 3;

    localparam int K_RGB  = 0;
    localparam int K_HS   = 1;
    localparam int K_VS   = 2;
    localparam int K_FS   = 3;
    localparam int K_ADDR = 4;
    localparam int K_UND  = 5;

    localparam int FRAME = 420000;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [15:0] vram_addr;
    logic [15:0] vram_q;
    logic [3:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, frame_start, underrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
    } exp_t;

    exp_t sbq[$];

    always #5 clock = ~clock;

    vram_scanout #(.BASE_ADDR(BASE), .READ_LATENCY(LAT)) dut (
        .clock       (clock),
        .clear       (clear),
        .vram_addr   (vram_addr),
        .vram_q      (vram_q),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    // VRAM contents: three marker words, everything else {C, offset[11:0]}
    function automatic logic [15:0] ram_word(input logic [15:0] a);
        logic [15:0] off;
        off = a - BASE;
        if (off == 16'd0)   return 16'h0F00;
        if (off == 16'd1)   return 16'h00F0;
        if (off == 16'd160) return 16'h000F;
        return {4'hC, off[11:0]};
    endfunction

    // RAM model with LAT clocks from address to data
    logic [15:0] rq [LAT];
    always @(posedge clock) begin
        rq[0] <= ram_word(vram_addr);
        for (int k = 1; k < LAT; k++) rq[k] <= rq[k-1];
    end
    assign vram_q = rq[LAT-1];

    // clocks since clear release
    always @(posedge clock or posedge clear) begin
        if (clear) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic string kname(input int k);
        case (k)
            K_RGB:  return "rgb";
            K_HS:   return "hsync";
            K_VS:   return "vsync";
            K_FS:   return "frame_start";
            K_ADDR: return "vram_addr";
            default: return "underrun";
        endcase
    endfunction

    function automatic logic [15:0] sample(input int k);
        case (k)
            K_RGB:  return {4'h0, VGA_R, VGA_G, VGA_B};
            K_HS:   return {15'd0, VGA_HS};
            K_VS:   return {15'd0, VGA_VS};
            K_FS:   return {15'd0, frame_start};
            K_ADDR: return vram_addr;
            default: return {15'd0, underrun};
        endcase
    endfunction

    function automatic void push(input int c, input int k, input logic [15:0] v);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        i = sbq.size();
        while (i > 0 && sbq[i-1].cyc > c) i--;
        sbq.insert(i, e);
    endfunction

    // pixel (x,y) of frame f appears on the pins one clock after the raster reaches it
    function automatic void push_px(input int f, input int x, input int y, input logic [11:0] rgb);
        push(f * FRAME + y * 800 + x + 1, K_RGB, {4'h0, rgb});
    endfunction

    function automatic void push_reset_state();
        push(0, K_RGB, 16'h0000);
        push(0, K_HS, 16'd1);
        push(0, K_VS, 16'd1);
        push(0, K_FS, 16'd0);
        push(0, K_ADDR, BASE);
        push(0, K_UND, 16'd0);
    endfunction

    // Monitor: pop every expectation whose cycle has come and compare
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge clock);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e   = sbq.pop_front();
                act = sample(e.kind);
                total++;
                if (e.cyc != cyc) begin
                    bad++;
                    $display("FAIL %s: due at cyc %0d, monitor only reached it at cyc %0d", kname(e.kind), e.cyc, cyc);
                end else if (act !== e.val) begin
                    bad++;
                    $display("FAIL %s at cyc %0d: got %h, want %h", kname(e.kind), cyc, act, e.val);
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sbq.size() > 0; i++) @(negedge clock);
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations still pending at cyc %0d", sbq.size(), cyc);
            sbq.delete();
        end
    endtask

    task automatic wait_cyc(input int target, input int budget);
        for (int i = 0; i < budget && cyc != target; i++) @(negedge clock);
        total++;
        if (cyc != target) begin
            bad++;
            $display("FAIL wait_cyc: got cyc %0d, want %0d", cyc, target);
        end
    endtask

    initial begin
        // reset state while clear is held
        repeat (3) @(negedge clock);
        push_reset_state();
        repeat (3) @(negedge clock);

        // first frame after release: timing, fetch addresses, black screen
        push(1,    K_ADDR, BASE + 16'd160);
        push(2,    K_ADDR, BASE + 16'd161);
        push(160,  K_ADDR, BASE + 16'd319);
        push(161,  K_ADDR, BASE + 16'd319);
        push(700,  K_ADDR, BASE + 16'd319);
        push(3201, K_ADDR, BASE + 16'd320);
        push(FRAME - 800 + 1, K_ADDR, BASE);
        push(FRAME - 800 + 2, K_ADDR, BASE + 16'd1);
        push(FRAME - 800 + 160, K_ADDR, BASE + 16'd159);
        push(1,    K_FS, 16'd0);
        push(656,  K_HS, 16'd1);
        push(657,  K_HS, 16'd0);
        push(752,  K_HS, 16'd0);
        push(753,  K_HS, 16'd1);
        push(392000, K_VS, 16'd1);
        push(392001, K_VS, 16'd0);
        push(393600, K_VS, 16'd0);
        push(393601, K_VS, 16'd1);
        push_px(0, 0,   0,  12'h000);
        push_px(0, 100, 50, 12'h000);

        // second frame: first valid frame_start and image content
        push(FRAME,     K_FS, 16'd0);
        push(FRAME + 1, K_FS, 16'd1);
        push(FRAME + 2, K_FS, 16'd0);
        push_px(1, 0,   0,  12'hF00);
        push_px(1, 3,   3,  12'hF00);
        push_px(1, 4,   0,  12'h0F0);
        push_px(1, 7,   3,  12'h0F0);
        push_px(1, 0,   4,  12'h00F);
        push_px(1, 3,   7,  12'h00F);
        push_px(1, 4,   4,  12'h0A1);
        push_px(1, 8,   5,  12'h0A2);
        push_px(1, 639, 7,  12'h13F);
        push_px(1, 640, 0,  12'h000);
        push_px(1, 100, 10, 12'h159);
        push(FRAME + 8200, K_UND, 16'd0);

        clear = 1'b0;
        wait_drain(FRAME + 20000);

        // clear in the middle of the line-12 fetch (frame 2, h=50)
        wait_cyc(FRAME + 12 * 800 + 50, 5000);
        clear = 1'b1;
        #1;
        push_reset_state();
        repeat (5) @(negedge clock);

        // after release: black until the next group-0 prefetch, fetch restarts cleanly
        push(1,    K_FS, 16'd0);
        push(1,    K_ADDR, BASE + 16'd160);
        push(2,    K_ADDR, BASE + 16'd161);
        push(657,  K_HS, 16'd0);
        push_px(0, 0, 0, 12'h000);
        push_px(0, 0, 4, 12'h000);
        push_px(0, 4, 4, 12'h000);
        push(3300, K_UND, 16'd0);
        clear = 1'b0;
        wait_drain(10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
